// File: rtl/sha256_compress_ctrl.sv
// sha256_compress_ctrl: SHA-256 compression sequencer.
// Accepts 512-bit padded blocks, runs 64 rounds (UNROLL rounds per clock) with a
// 16-word sliding message schedule, chains the hash across blocks and presents
// the final digest over a valid/ready handshake.
// Optional build macro: SHA224_SUPPORT_EN adds the mode_224 input (SHA-224 IV and
// truncated digest). Without it the block is SHA-256 only.

package sha256_pkg;

  typedef logic [0:7][31:0] hash_t;

  localparam hash_t IV_256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam hash_t IV_224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

endpackage

module sha256_compress_ctrl #(
  parameter int UNROLL    = 1,   // rounds per clock: 1, 2 or 4
  parameter int WORD_SIZE = 32   // fixed at 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
  input  logic         blk_last,
`ifdef SHA224_SUPPORT_EN
  input  logic         mode_224,
`endif
  output logic         digest_valid,
  input  logic         digest_ready,
  output logic [255:0] digest,
  output logic         busy
);

  typedef logic [WORD_SIZE-1:0] word_t;
  typedef logic [0:15][WORD_SIZE-1:0] window_t;
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, OUT} state_t;

  localparam logic [5:0] STEP     = 6'(UNROLL);
  localparam logic [5:0] LAST_CNT = 6'(64 - UNROLL);

  state_t            state, state_nxt;
  logic [5:0]        cnt;
  logic              last_q;
  logic              mode_q;
  logic              mode_sel;
  logic              accept;
  sha256_pkg::hash_t h_reg, v_reg, v_nxt, iv_sel;
  window_t           w_reg, w_nxt;

  function automatic word_t rotr(input word_t x, input int n);
    return (x >> n) | (x << (WORD_SIZE - n));
  endfunction

  function automatic word_t big_s0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_s1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t small_s0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t small_s1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  // One FIPS 180-4 round on working variables a..h (index 0..7).
  function automatic sha256_pkg::hash_t sha_round(input sha256_pkg::hash_t s,
                                                  input word_t k, input word_t w);
    word_t             t1;
    word_t             t2;
    sha256_pkg::hash_t r;
    t1   = s[7] + big_s1(s[4]) + ch(s[4], s[5], s[6]) + k + w;
    t2   = big_s0(s[0]) + maj(s[0], s[1], s[2]);
    r[0] = t1 + t2;
    r[1] = s[0];
    r[2] = s[1];
    r[3] = s[2];
    r[4] = s[3] + t1;
    r[5] = s[4];
    r[6] = s[5];
    r[7] = s[6];
    return r;
  endfunction

  // Extend the window by UNROLL words and slide it forward by the same amount.
  // Words produced beyond W[63] during the last cycle are never consumed.
  function automatic window_t next_window(input window_t w);
    word_t   ext [0:15+UNROLL];
    window_t r;
    for (int i = 0; i < 16; i++) ext[i] = w[i];
    for (int j = 0; j < UNROLL; j++)
      ext[16+j] = small_s1(ext[14+j]) + ext[9+j] + small_s0(ext[1+j]) + ext[j];
    for (int i = 0; i < 16; i++) r[i] = ext[i+UNROLL];
    return r;
  endfunction

  // Apply UNROLL consecutive rounds starting at round t; W[t+j] sits at w[j].
  function automatic sha256_pkg::hash_t run_rounds(input sha256_pkg::hash_t s,
                                                   input window_t w, input logic [5:0] t);
    sha256_pkg::hash_t r;
    r = s;
    for (int j = 0; j < UNROLL; j++) r = sha_round(r, sha256_pkg::K[t + 6'(j)], w[j]);
    return r;
  endfunction

`ifdef SHA224_SUPPORT_EN
  assign mode_sel = mode_224;
`else
  assign mode_sel = 1'b0;
`endif

  assign iv_sel = mode_sel ? sha256_pkg::IV_224 : sha256_pkg::IV_256;
  assign accept = blk_valid && blk_ready;
  assign w_nxt  = next_window(w_reg);
  assign v_nxt  = run_rounds(v_reg, w_reg, cnt);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_nxt    = state;
    blk_ready    = 1'b0;
    digest_valid = 1'b0;
    busy         = 1'b1;
    unique case (state)
      IDLE: begin
        blk_ready = 1'b1;
        busy      = 1'b0;
        if (blk_valid) state_nxt = ROUND;
      end
      ROUND: if (cnt == LAST_CNT) state_nxt = FINAL;
      FINAL: state_nxt = last_q ? OUT : IDLE;
      OUT: begin
        digest_valid = 1'b1;
        if (digest_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Round counter, last-block flag and digest mode latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      last_q <= 1'b0;
      mode_q <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      last_q <= blk_last;
      if (blk_first) mode_q <= mode_sel;
    end else if (state == ROUND) begin
      cnt <= cnt + STEP;
    end
  end

  // Chaining value: IV on reset or first block, feed-forward add after the rounds.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_reg <= sha256_pkg::IV_256;
    end else if (accept && blk_first) begin
      h_reg <= iv_sel;
    end else if (state == FINAL) begin
      for (int i = 0; i < 8; i++) h_reg[i] <= h_reg[i] + v_reg[i];
    end
  end

  // Message window and working variables; contents only meaningful after an accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      w_reg <= blk_data;
      v_reg <= blk_first ? iv_sel : h_reg;
    end else if (state == ROUND) begin
      w_reg <= w_nxt;
      v_reg <= v_nxt;
    end
  end

  // Digest is driven only while valid; SHA-224 zeroes the dropped H7 word.
  always_comb begin
    digest = '0;
    if (digest_valid) begin
      digest = h_reg;
      if (mode_q) digest[31:0] = '0;
    end
  end

endmodule

// File: doc/sha256_compress_ctrl.md
Name: sha256_compress_ctrl

Overview:
Sequencer for the SHA-256 compression function. It accepts 512-bit padded message blocks over a valid/ready handshake and runs the FIPS 180-4 round loop with a 16-word sliding message schedule. It chains the intermediate hash across multi-block messages and presents the final 256-bit digest over a second valid/ready handshake. It sits between the padding front-end and the digest consumer, and uses the shared sha256_pkg constants (K, H).

Parameters:
UNROLL, 1, rounds computed per clock; legal values 1, 2, 4; round phase lasts 64/UNROLL cycles
WORD_SIZE, 32, word width; fixed, not to be overridden

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous reset, active-high
blk_valid  in  1  block present on blk_data
blk_ready  out  1  controller can accept a block; high only in IDLE
blk_data  in  512  padded block; W0 = [511:480], W15 = [31:0]
blk_first  in  1  first block of a message; chaining value loads from IV
blk_last  in  1  last block of a message; produce digest after it
digest_valid  out  1  digest holds the final hash
digest_ready  in  1  consumer accepts the digest
digest  out  256  H0 = [255:224] ... H7 = [31:0]
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: blk_ready=1, digest_valid=0, digest=0, busy=0. State goes to IDLE, H registers to the sha256_pkg IV, round counter to 0.
- States are IDLE, ROUND, FINAL, OUT.
- IDLE: on blk_valid&&blk_ready (cycle T):
  - latch W window from blk_data and latch blk_last.
  - a..h load IV if blk_first, else current H registers. H registers also reload IV when blk_first.
  - next state ROUND.
- ROUND (cycles T+1 .. T+64/UNROLL):
  - each cycle applies UNROLL rounds t..t+UNROLL-1. Round t uses K[t] and W[t].
  - W[t] for t>=16 = sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16], mod 2^32. The window shifts by UNROLL words per cycle.
  - the counter counts in steps of UNROLL and leaves ROUND after round 63.
- Round functions are exactly FIPS 180-4:
  - Ch = (x&y)^(~x&z); Maj = (x&y)^(x&z)^(y&z)
  - Σ0 = ROTR2^ROTR13^ROTR22; Σ1 = ROTR6^ROTR11^ROTR25
  - σ0 = ROTR7^ROTR18^SHR3; σ1 = ROTR17^ROTR19^SHR10
  - all additions mod 2^32, carries discarded.
- FINAL (cycle T+64/UNROLL+1): Hi <= Hi + working var i, mod 2^32. Next state is OUT if the latched last flag is set, else IDLE.
- OUT: digest_valid=1 from cycle T+64/UNROLL+2, digest = H registers. Hold stable until digest_ready; on that handshake go to IDLE.
- Latency with UNROLL=1: block accept to digest_valid = 66 cycles. A non-last block re-raises blk_ready at T+66.
- Boundary conditions:
  - blk_valid outside IDLE is ignored; the block is not consumed (blk_ready=0).
  - blk_first && blk_last: a single-block message.
  - Non-first block after reset: chains from IV, because reset loaded IV into H.
  - digest_ready held low: stall indefinitely in OUT; no new block is accepted.
  - digest_ready high with digest_valid low: no effect.
  - rst in any state, including mid-ROUND: abort and return to reset values on the next edge; partial state is discarded.
- blk_data, blk_first and blk_last are sampled only on the accept cycle.

Optional Feature:
SHA224_SUPPORT_EN
- Defined: adds input port mode_224 (1 bit), sampled with blk_first.
  - When mode_224=1, IV is the SHA-224 IV: c1059ed8 367cd507 3070dd17 f70e5939 ffc00b31 68581511 64f98fa7 befa4fa4.
  - digest[255:32] = H0..H6 and digest[31:0] = 0.
  - The mode latch persists across the message's blocks.
- Undefined: no port; SHA-256 only. Behaviour is otherwise identical.

Test Plan:
- "abc": block 61626380, then 13 zero words, then 00000018; first=last=1 -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, digest_valid exactly 66 cycles after accept (UNROLL=1).
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (first then last, back-to-back) -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1; blk_ready low throughout the first block's rounds.
- digest_ready held low 20 cycles with blk_valid high -> digest stable, blk_ready=0, no block consumed; digest_ready=1 -> IDLE next cycle, blk_ready=1.
- rst pulsed at round 30 of "abc", then "abc" re-sent -> correct "abc" digest; no digest_valid pulse from the aborted run.
- UNROLL=2 and UNROLL=4 with "abc" -> same digest, digest_valid 34 and 18 cycles after accept respectively.
- SHA224_SUPPORT_EN, mode_224=1, "abc" -> digest[255:32] = 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7, digest[31:0] = 0.
